// File: rtl/jtag_tap_responder_pkg.sv
// Shared TAP definitions: state encoding, opcodes, and the 1149.1
// next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    Ex2DR   = 4'h0,
    Ex1DR   = 4'h1,
    ShDR    = 4'h2,
    PauseDR = 4'h3,
    SelIR   = 4'h4,
    UpdDR   = 4'h5,
    CapDR   = 4'h6,
    SelDR   = 4'h7,
    Ex2IR   = 4'h8,
    Ex1IR   = 4'h9,
    ShIR    = 4'hA,
    PauseIR = 4'hB,
    RTI     = 4'hC,
    UpdIR   = 4'hD,
    CapIR   = 4'hE,
    TLR     = 4'hF
  } tap_state_e;

  localparam logic [4:0] OP_IDCODE = 5'h01;
  localparam logic [4:0] OP_USER   = 5'h10;
  localparam logic [4:0] OP_BYPASS = 5'h1F;

  function automatic tap_state_e tap_next(
    input tap_state_e s,
    input logic       tms
  );
    tap_next = TLR;
    unique case (s)
      TLR:     tap_next = tms ? TLR     : RTI;
      RTI:     tap_next = tms ? SelDR   : RTI;
      SelDR:   tap_next = tms ? SelIR   : CapDR;
      CapDR:   tap_next = tms ? Ex1DR   : ShDR;
      ShDR:    tap_next = tms ? Ex1DR   : ShDR;
      Ex1DR:   tap_next = tms ? UpdDR   : PauseDR;
      PauseDR: tap_next = tms ? Ex2DR   : PauseDR;
      Ex2DR:   tap_next = tms ? UpdDR   : ShDR;
      UpdDR:   tap_next = tms ? SelDR   : RTI;
      SelIR:   tap_next = tms ? TLR     : CapIR;
      CapIR:   tap_next = tms ? Ex1IR   : ShIR;
      ShIR:    tap_next = tms ? Ex1IR   : ShIR;
      Ex1IR:   tap_next = tms ? UpdIR   : PauseIR;
      PauseIR: tap_next = tms ? Ex2IR   : PauseIR;
      Ex2IR:   tap_next = tms ? UpdIR   : ShIR;
      UpdIR:   tap_next = tms ? SelDR   : RTI;
      default: tap_next = TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_responder_if.sv
// JTAG pin bundle shared between the probe side and the TAP target.
interface jtag_tap_responder_if;

  logic TCK;
  logic TMS;
  logic TDI;
  logic TRST;
  logic TDO;
  logic DRV_TDO;

  modport master (
    output TCK, TMS, TDI, TRST,
    input  TDO, DRV_TDO
  );

  modport slave (
    input  TCK, TMS, TDI, TRST,
    output TDO, DRV_TDO
  );

endinterface

// File: rtl/jtag_tap_responder_sync_edge.sv
// Pin synchronizer for TCK/TMS/TDI/TRST plus TCK edge strobes.
module jtag_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_tck,
  input  logic i_tms,
  input  logic i_tdi,
  input  logic i_trst,
  output logic o_tms,
  output logic o_tdi,
  output logic o_trst,
  output logic o_tck_rise,
  output logic o_tck_fall
);

  logic [3:0] r_sync [SYNC_STAGES];
  logic       r_tck_d;
  logic [3:0] w_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        r_sync[i] <= '0;
      r_tck_d <= 1'b0;
    end else begin
      r_sync[0] <= {i_trst, i_tdi, i_tms, i_tck};
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      r_tck_d <= r_sync[SYNC_STAGES-1][0];
    end
  end

  // All four pins share one chain so TMS/TDI stay aligned with TCK.
  assign w_last     = r_sync[SYNC_STAGES-1];
  assign o_tms      = w_last[1];
  assign o_tdi      = w_last[2];
  assign o_trst     = w_last[3];
  assign o_tck_rise = w_last[0] & ~r_tck_d;
  assign o_tck_fall = ~w_last[0] & r_tck_d;

endmodule

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP target in the system clock domain with IDCODE,
// BYPASS and a USER data register.
module jtag_tap_responder
  import jtag_pkg::*;
#(
  parameter int                  SYNC_STAGES  = 2,
  parameter int                  IR_WIDTH     = 5,
  parameter int                  DR_WIDTH     = 32,
  parameter logic [31:0]         IDCODE_VALUE = 32'h20000913,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(OP_IDCODE),
  parameter logic [IR_WIDTH-1:0] USER_INSTR   = IR_WIDTH'(OP_USER)
) (
  input  logic                clock,
  input  logic                reset,
  jtag_tap_responder_if.slave jtag,
  output logic [IR_WIDTH-1:0] ir_value,
  input  logic [DR_WIDTH-1:0] user_capture_data,
  output logic [DR_WIDTH-1:0] user_update_data,
  output logic                user_update_valid,
  output logic                user_capture_pulse
);

  localparam int DRW = (DR_WIDTH > 32) ? DR_WIDTH : 32;
  localparam logic [IR_WIDTH-1:0] BYPASS_INSTR = '1;

  logic w_tms, w_tdi, w_trst, w_rise, w_fall;

  jtag_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock      (clock),
    .reset      (reset),
    .i_tck      (jtag.TCK),
    .i_tms      (jtag.TMS),
    .i_tdi      (jtag.TDI),
    .i_trst     (jtag.TRST),
    .o_tms      (w_tms),
    .o_tdi      (w_tdi),
    .o_trst     (w_trst),
    .o_tck_rise (w_rise),
    .o_tck_fall (w_fall)
  );

  tap_state_e          r_state;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_sh;
  logic [DRW-1:0]      r_dr_sh;
  logic                r_byp;
  logic                r_tdo;
  logic                r_drv;
  logic [DR_WIDTH-1:0] r_upd;
  logic                r_upd_v;
  logic                r_cap_p;

  tap_state_e          w_next;
  logic                w_sel_idc;
  logic                w_sel_user;
  logic                w_sel_byp;
  logic [DRW-1:0]      w_dr_next;

  assign w_next     = tap_next(r_state, w_tms);
  assign w_sel_idc  = (r_ir == IDCODE_INSTR) && (r_ir != BYPASS_INSTR);
  assign w_sel_user = (r_ir == USER_INSTR) && (r_ir != BYPASS_INSTR);
  assign w_sel_byp  = !w_sel_idc && !w_sel_user;

  // TDI enters at the top of whichever register length is selected.
  always_comb begin
    w_dr_next = r_dr_sh >> 1;
    if (w_sel_user)
      w_dr_next[DR_WIDTH-1] = w_tdi;
    else
      w_dr_next[31] = w_tdi;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= TLR;
      r_ir    <= IDCODE_INSTR;
      r_ir_sh <= '0;
      r_dr_sh <= '0;
      r_byp   <= 1'b0;
      r_tdo   <= 1'b0;
      r_drv   <= 1'b0;
      r_upd   <= '0;
      r_upd_v <= 1'b0;
      r_cap_p <= 1'b0;
    end else begin
      r_upd_v <= 1'b0;
      r_cap_p <= 1'b0;
      if (w_trst) begin
        r_state <= TLR;
        r_ir    <= IDCODE_INSTR;
      end else if (w_rise) begin
        r_state <= w_next;
        unique case (1'b1)
          (r_state == CapIR):
            r_ir_sh <= IR_WIDTH'(2'b01);
          (r_state == ShIR):
            r_ir_sh <= {w_tdi, r_ir_sh[IR_WIDTH-1:1]};
          (r_state == CapDR): begin
            r_byp <= 1'b0;
            if (w_sel_idc)
              r_dr_sh <= DRW'(IDCODE_VALUE);
            else if (w_sel_user)
              r_dr_sh <= DRW'(user_capture_data);
          end
          (r_state == ShDR): begin
            if (w_sel_byp)
              r_byp <= w_tdi;
            else
              r_dr_sh <= w_dr_next;
          end
          default: ;
        endcase
        if (w_next == TLR)
          r_ir <= IDCODE_INSTR;
        if (w_next == UpdIR)
          r_ir <= r_ir_sh;
        if (w_next == UpdDR && w_sel_user) begin
          r_upd   <= r_dr_sh[DR_WIDTH-1:0];
          r_upd_v <= 1'b1;
        end
        if (w_next == CapDR && w_sel_user)
          r_cap_p <= 1'b1;
      end
      if (w_fall) begin
        unique case (1'b1)
          (r_state == ShDR): begin
            r_tdo <= w_sel_byp ? r_byp : r_dr_sh[0];
            r_drv <= 1'b1;
          end
          (r_state == ShIR): begin
            r_tdo <= r_ir_sh[0];
            r_drv <= 1'b1;
          end
          default: r_drv <= 1'b0;
        endcase
      end
    end
  end

  assign jtag.TDO           = r_tdo;
  assign jtag.DRV_TDO       = r_drv;
  assign ir_value           = r_ir;
  assign user_update_data   = r_upd;
  assign user_update_valid  = r_upd_v;
  assign user_capture_pulse = r_cap_p;

endmodule
